// File: rtl/lsu_pkg.sv
// lsu_pkg: access size encodings, FSM states and lane helpers for the load/store unit
package lsu_pkg;
  localparam int MEM_DATA_W = 64;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_e;
  function automatic logic [MEM_DATA_W-1:0] lane_mask(input size_e s);
    return s == SZ_B ? 64'hFF : s == SZ_H ? 64'hFFFF : s == SZ_W ? 64'hFFFF_FFFF : '1;
  endfunction
  function automatic logic [2:0] align_mask(input size_e s);
    return s == SZ_B ? 3'd0 : s == SZ_H ? 3'd1 : s == SZ_W ? 3'd3 : 3'd7;
  endfunction
endpackage

// File: rtl/lsu_lane_unit.sv
// lsu_lane_unit: load lane extract/extend and sub-word store merge into a full memory word
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [MEM_DATA_W-1:0] word_i,
  input  logic [2:0]            off_i,
  input  size_e                 size_i,
  input  logic                  signed_i,
  input  logic [MEM_DATA_W-1:0] wdata_i,
  output logic [MEM_DATA_W-1:0] load_o,
  output logic [MEM_DATA_W-1:0] merge_o
);
  logic [5:0] sh;
  logic [MEM_DATA_W-1:0] lane, mask;
  assign sh = {off_i, 3'b000};
  assign lane = word_i >> sh;
  assign mask = lane_mask(size_i) << sh;
  assign load_o = size_i == SZ_B ? {{56{signed_i & lane[7]}}, lane[7:0]} :
                  size_i == SZ_H ? {{48{signed_i & lane[15]}}, lane[15:0]} :
                  size_i == SZ_W ? {{32{signed_i & lane[31]}}, lane[31:0]} : lane;
  assign merge_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding LDUR/STUR initiator for a 64-bit word memory, sub-word stores via RMW.
// Optional LSU_ACCESS_CNT_EN adds load/store/fault counters.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [63:0] mem_address,
  output logic        mem_readMem,
  output logic        mem_writeMem,
  output logic [63:0] mem_dataInput,
  input  logic [63:0] mem_dataOutput
`ifdef LSU_ACCESS_CNT_EN
  ,
  output logic [CNT_W-1:0] load_count,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] fault_count
`endif
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  state_e state_q;
  logic [IDX_W-1:0] idx_q;
  logic [2:0] off_q;
  size_e size_q;
  logic signed_q, write_q, fault_q;
  logic [63:0] buf_q, rdata_q, load_data, merged;
  size_e req_sz;
  logic fault;
  assign req_sz = size_e'(req_size);
  assign fault = |(req_addr[2:0] & align_mask(req_sz)) || req_addr[63:3] >= 61'(DEPTH_WORDS);
  lsu_lane_unit u_lane (
    .word_i   (mem_dataOutput),
    .off_i    (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .wdata_i  (buf_q),
    .load_o   (load_data),
    .merge_o  (merged)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      off_q <= '0;
      size_q <= SZ_B;
      signed_q <= 1'b0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      buf_q <= '0;
      rdata_q <= '0;
    end else
      case (state_q)
        IDLE: if (req_valid) begin
          idx_q <= req_addr[3 +: IDX_W];
          off_q <= req_addr[2:0];
          size_q <= req_sz;
          signed_q <= req_signed;
          write_q <= req_write;
          buf_q <= req_wdata;
          fault_q <= fault;
          rdata_q <= '0;
          state_q <= fault ? RESP : (req_write && req_sz == SZ_D) ? WR : RD;
        end
        RD: state_q <= CAP;
        CAP: if (write_q) begin
          buf_q <= merged;
          state_q <= WR;
        end else begin
          rdata_q <= load_data;
          state_q <= RESP;
        end
        WR: state_q <= RESP;
        RESP: if (resp_ready) begin
          rdata_q <= '0;
          fault_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
`ifdef LSU_ACCESS_CNT_EN
  always_ff @(posedge clk)
    if (reset) begin
      load_count <= '0;
      store_count <= '0;
      fault_count <= '0;
    end else if (state_q == RESP && resp_ready) begin
      if (fault_q) fault_count <= fault_count + 1'b1;
      else if (write_q) store_count <= store_count + 1'b1;
      else load_count <= load_count + 1'b1;
    end
`endif
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;
  // Strobes are masked by reset so an in-flight access never touches memory during reset.
  assign mem_readMem = !reset && state_q == RD;
  assign mem_writeMem = !reset && state_q == WR;
  assign mem_address = (state_q == RD || state_q == CAP || state_q == WR) ? 64'(idx_q) : '0;
  assign mem_dataInput = state_q == WR ? buf_q : '0;
endmodule
